// File: rtl/softmax_max_sub_pkg.sv
// Shared definitions for the softmax pre-exponential stage: binary32 field
// layout, FSM encodings and a leading-one helper used by the subtractor.
package softmax_max_sub_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    // Extended mantissa: hidden bit, fraction and three guard bits.
    localparam int EXT_W     = MANT_W + 4;
    localparam int MAX_SHIFT = 26;

    localparam logic [31:0] FP_NEG_INF = 32'hFF800000;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    typedef struct packed {
        logic                       sign;
        logic [EXP_MSB-EXP_LSB:0]   exp;
        logic [MANT_W-1:0]          mant;
    } fp32_t;

    function automatic logic [4:0] lead_pos(input logic [EXT_W-1:0] v);
        logic [4:0] pos;
        pos = '0;
        for (int i = 0; i < EXT_W; i++) begin
            if (v[i]) pos = 5'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/softmax_max_sub_fp_sub.sv
// Combinational binary32 x - m for m >= x: truncating, flush-to-zero,
// alignment shift clamped, result always non-positive.
module fp_sub
    import softmax_max_sub_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] m,
    output logic [31:0] diff
);

    fp32_t              xf;
    fp32_t              mf;
    logic [EXT_W-1:0]   x_ext;
    logic [EXT_W-1:0]   m_ext;
    logic [EXT_W-1:0]   big_ext;
    logic [EXT_W-1:0]   small_ext;
    logic [EXT_W-1:0]   small_sh;
    logic [7:0]         big_exp;
    logic [7:0]         small_exp;
    logic [7:0]         exp_gap;
    logic [4:0]         shift;
    logic [EXT_W:0]     mag;
    logic [EXT_W-1:0]   norm;
    logic [4:0]         lead;
    logic [4:0]         lz;
    logic signed [9:0]  res_exp;
    logic               x_bigger;

    always_comb begin
        xf = x;
        mf = m;
        x_ext = (xf.exp == '0) ? '0 : {1'b1, xf.mant, 3'b000};
        m_ext = (mf.exp == '0) ? '0 : {1'b1, mf.mant, 3'b000};

        // Magnitude order decides which operand gets aligned; the sign of
        // the result is already known to be negative.
        x_bigger  = {xf.exp, x_ext} > {mf.exp, m_ext};
        big_ext   = x_bigger ? x_ext : m_ext;
        small_ext = x_bigger ? m_ext : x_ext;
        big_exp   = x_bigger ? xf.exp : mf.exp;
        small_exp = x_bigger ? mf.exp : xf.exp;

        exp_gap  = big_exp - small_exp;
        shift    = (exp_gap > 8'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : exp_gap[4:0];
        small_sh = small_ext >> shift;

        if (xf.sign == mf.sign) begin
            mag = {1'b0, big_ext} - {1'b0, small_sh};
        end else begin
            mag = {1'b0, big_ext} + {1'b0, small_sh};
        end

        lead = lead_pos(mag[EXT_W-1:0]);
        lz   = 5'(EXT_W - 1) - lead;
        if (mag[EXT_W]) begin
            norm    = mag[EXT_W:1];
            res_exp = $signed({2'b00, big_exp}) + 10'sd1;
        end else begin
            norm    = mag[EXT_W-1:0] << lz;
            res_exp = $signed({2'b00, big_exp}) - $signed({5'b00000, lz});
        end

        if (mag == '0 || res_exp <= 10'sd0) begin
            diff = 32'h0;
        end else if (res_exp >= 10'sd255) begin
            diff = FP_NEG_INF;
        end else begin
            diff = {1'b1, res_exp[7:0], norm[EXT_W-2 -: MANT_W]};
        end
    end

endmodule

// File: rtl/softmax_max_sub.sv
// Buffers N binary32 scores while tracking their maximum, then streams
// x_i - max one element per handshake to the exponential unit.
module softmax_max_sub
    import softmax_max_sub_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [1:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] buf_r [N];
    logic [DATA_WIDTH-1:0] max_r;
    logic [DATA_WIDTH-1:0] out_r;
    logic                  last_r;
    logic [DATA_WIDTH-1:0] sub_res;
    logic                  accept;

    // Sign-magnitude ordering; +0 and -0 are equal, so neither is greater.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            return !a[SIGN_BIT] && !(a[30:0] == '0 && b[30:0] == '0);
        end else if (!a[SIGN_BIT]) begin
            return a[30:0] > b[30:0];
        end else begin
            return a[30:0] < b[30:0];
        end
    endfunction

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_EMIT);
    assign out_last  = (state == ST_EMIT) && last_r;
    assign out_data  = out_r;
    assign accept    = in_valid && in_ready;

    fp_sub u_fp_sub (
        .x    (buf_r[idx]),
        .m    (max_r),
        .diff (sub_res)
    );

    always_ff @(posedge clk) begin
        if (accept) buf_r[idx] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_LOAD;
            idx    <= '0;
            max_r  <= '0;
            out_r  <= '0;
            last_r <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        // Strict compare keeps the first of equal maxima.
                        if (idx == '0 || fp_gt(in_data, max_r)) max_r <= in_data;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_CALC;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_CALC: begin
                    out_r  <= sub_res;
                    last_r <= (idx == LAST_IDX);
                    state  <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (last_r) begin
                            idx   <= '0;
                            state <= ST_LOAD;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_CALC;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
